// File: rtl/imm_encoder.sv
// imm_encoder: two-stage pipelined RISC-V immediate encoder.
// Takes a base instruction word, a signed immediate and an ImmSrc format
// code (00 I, 01 S, 10 B, 11 J) and scatters the immediate into the
// format's bit fields. The immediate is range/alignment checked.
// Stage 1 registers the range check and a field image plus bit mask.
// Stage 2 merges the field image into the base word and drives the outputs.
// A valid/ready handshake is provided on both sides.
// Optional feature macro: IMM_ENCODER_ROUNDTRIP_EN. When it is defined, the
// merged word is decoded back with extender semantics and checked against
// the original immediate, with a sticky rt_fail flag.
module imm_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  ImmSrc,
    input  logic [31:0] imm,
    input  logic [31:0] base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        err,
    output logic [7:0]  err_count
`ifdef IMM_ENCODER_ROUNDTRIP_EN
    ,
    output logic        rt_fail
`endif
);

    localparam logic [1:0] FMT_I = 2'b00;
    localparam logic [1:0] FMT_S = 2'b01;
    localparam logic [1:0] FMT_B = 2'b10;
    localparam logic [1:0] FMT_J = 2'b11;

    // Bits of the instruction word owned by each immediate format
    localparam logic [31:0] MASK_I  = 32'hFFF0_0000;
    localparam logic [31:0] MASK_SB = 32'hFE00_0F80;
    localparam logic [31:0] MASK_J  = 32'hFFFF_F000;

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic        s1_valid_reg;
    logic [31:0] s1_base_reg;
    logic [31:0] s1_field_reg;
    logic [31:0] s1_mask_reg;
    logic        s1_err_reg;

    logic        s2_valid_reg;
    logic [31:0] s2_instr_reg;
    logic        s2_err_reg;

    logic [7:0]  err_count_reg;
    logic [7:0]  err_count_next;

    // Handshake controls
    logic        s2_load;
    logic        s1_load;
    logic        s1_capture;
    logic        s2_capture;

    // Stage 2 may refill whenever it is empty or its word leaves this cycle;
    // stage 1 may refill whenever it is empty or its word moves to stage 2.
    assign s2_load    = !s2_valid_reg || out_ready;
    assign s1_load    = !s1_valid_reg || s2_load;
    assign in_ready   = s1_load;
    assign s1_capture = s1_load && in_valid;
    assign s2_capture = s2_load && s1_valid_reg;

    // ------------------------------------------------------------------
    // Stage 1 combinational: range check and field slicing
    // ------------------------------------------------------------------
    logic        ext11_ok;
    logic        ext12_ok;
    logic        ext20_ok;
    logic        range_err_next;
    logic [31:0] field_next;
    logic [31:0] mask_next;

    // The upper bits must be a pure sign extension of the encodable range
    assign ext11_ok = (&imm[31:11]) || !(|imm[31:11]);
    assign ext12_ok = (&imm[31:12]) || !(|imm[31:12]);
    assign ext20_ok = (&imm[31:20]) || !(|imm[31:20]);

    // Place the immediate into its format's fields and flag range/alignment errors
    always_comb begin
        range_err_next = 1'b0;
        field_next     = 32'h0000_0000;
        mask_next      = 32'h0000_0000;
        case (ImmSrc)
            FMT_I: begin
                range_err_next = !ext11_ok;
                field_next     = {imm[11:0], 20'b0};
                mask_next      = MASK_I;
            end
            FMT_S: begin
                range_err_next = !ext11_ok;
                field_next     = {imm[11:5], 13'b0, imm[4:0], 7'b0};
                mask_next      = MASK_SB;
            end
            FMT_B: begin
                range_err_next = !ext12_ok || imm[0];
                field_next     = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
                mask_next      = MASK_SB;
            end
            FMT_J: begin
                range_err_next = !ext20_ok || imm[0];
                field_next     = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
                mask_next      = MASK_J;
            end
            default: begin
                range_err_next = 1'b0;
                field_next     = 32'h0000_0000;
                mask_next      = 32'h0000_0000;
            end
        endcase
    end

    // Stage 1 registers: valid follows the request when the stage refills
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_base_reg  <= 32'h0000_0000;
            s1_field_reg <= 32'h0000_0000;
            s1_mask_reg  <= 32'h0000_0000;
            s1_err_reg   <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid_reg <= in_valid;
            end
            if (s1_capture) begin
                s1_base_reg  <= base;
                s1_field_reg <= field_next;
                s1_mask_reg  <= mask_next;
                s1_err_reg   <= range_err_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: merge the field image into the base word
    // ------------------------------------------------------------------
    logic [31:0] merged_word;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_merge
            assign merged_word[gi] = s1_mask_reg[gi] ? s1_field_reg[gi] : s1_base_reg[gi];
        end
    endgenerate

    // Stage 2 registers: the output word holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_instr_reg <= 32'h0000_0000;
            s2_err_reg   <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_valid_reg <= s1_valid_reg;
            end
            if (s2_capture) begin
                s2_instr_reg <= merged_word;
                s2_err_reg   <= s1_err_reg;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign instr     = s2_instr_reg;
    assign err       = s2_err_reg;

    // ------------------------------------------------------------------
    // Error counter: counts flagged words as they are handed off, saturating
    // ------------------------------------------------------------------
    always_comb begin
        err_count_next = err_count_reg;
        if (s2_valid_reg && out_ready && s2_err_reg && (err_count_reg != 8'hFF)) begin
            err_count_next = err_count_reg + 8'd1;
        end
    end

    // Counter register, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_reg <= 8'h00;
        end else begin
            err_count_reg <= err_count_next;
        end
    end

    assign err_count = err_count_reg;

`ifdef IMM_ENCODER_ROUNDTRIP_EN
    // ------------------------------------------------------------------
    // Round-trip self check: decode the merged word the way the extender
    // would and compare with the original immediate.
    // ------------------------------------------------------------------
    logic [31:0] s1_imm_reg;
    logic [1:0]  s1_src_reg;
    logic [31:0] decoded_imm;
    logic        rt_fail_reg;

    // Keep the raw immediate and format alongside the stage 1 word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_imm_reg <= 32'h0000_0000;
            s1_src_reg <= 2'b00;
        end else if (s1_capture) begin
            s1_imm_reg <= imm;
            s1_src_reg <= ImmSrc;
        end
    end

    // Extender semantics applied to the merged word
    always_comb begin
        decoded_imm = 32'h0000_0000;
        case (s1_src_reg)
            FMT_I: decoded_imm = {{20{merged_word[31]}}, merged_word[31:20]};
            FMT_S: decoded_imm = {{20{merged_word[31]}}, merged_word[31:25], merged_word[11:7]};
            FMT_B: decoded_imm = {{20{merged_word[31]}}, merged_word[7], merged_word[30:25],
                                  merged_word[11:8], 1'b0};
            FMT_J: decoded_imm = {{12{merged_word[31]}}, merged_word[19:12], merged_word[20],
                                  merged_word[30:21], 1'b0};
            default: decoded_imm = 32'h0000_0000;
        endcase
    end

    // Sticky flag: an in-range word that fails to round-trip is a design fault
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rt_fail_reg <= 1'b0;
        end else if (s2_capture && !s1_err_reg && (decoded_imm != s1_imm_reg)) begin
            rt_fail_reg <= 1'b1;
        end
    end

    assign rt_fail = rt_fail_reg;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed-vector bench for imm_encoder with hand-computed
// expected words, error counting and saturation, backpressure, and
// asynchronous reset while words are in flight.
module tb_imm_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ImmSrc;
    logic [31:0] imm;
    logic [31:0] base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;
    logic [7:0]  err_count;
`ifdef IMM_ENCODER_ROUNDTRIP_EN
    logic        rt_fail;
`endif

    int check_cnt;
    int error_cnt;

    imm_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ImmSrc    (ImmSrc),
        .imm       (imm),
        .base      (base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .err       (err),
        .err_count (err_count)
`ifdef IMM_ENCODER_ROUNDTRIP_EN
        ,
        .rt_fail   (rt_fail)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request through an empty pipeline with out_ready held high.
    // Entered and left at 1 time unit after a rising edge.
    task automatic xact(input string tag, input logic [1:0] src, input logic [31:0] im,
                        input logic [31:0] b, input logic [31:0] exp_instr, input logic exp_err);
        ImmSrc   = src;
        imm      = im;
        base     = b;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_not_early"}, {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_instr"}, instr, exp_instr);
        check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
        $display("xact %s src=%0d imm=0x%08h base=0x%08h -> instr=0x%08h err=%0d",
                 tag, src, im, b, instr, err);
        @(posedge clk); #1;
    endtask

    initial begin
        int stall_cnt;
        check_cnt = 0;
        error_cnt = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ImmSrc    = 2'b00;
        imm       = 32'h0;
        base      = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_err_count", {24'b0, err_count}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);

        // Format vectors
        xact("i_neg1", 2'b00, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
        xact("s_8",    2'b01, 32'h0000_0008, 32'h0020_A023, 32'h0020_A423, 1'b0);
        xact("b_m4",   2'b10, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0);
        xact("j_800",  2'b11, 32'h0000_0800, 32'h0000_00EF, 32'h0010_00EF, 1'b0);
        check("count_after_ok", {24'b0, err_count}, 32'd0);

        // Error words: still encoded from truncated bits
        xact("b_odd",  2'b10, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1);
        check("count_1", {24'b0, err_count}, 32'd1);
        xact("i_800",  2'b00, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1);
        check("count_2", {24'b0, err_count}, 32'd2);

        // 300 back-to-back error words: full throughput, counter saturates
        stall_cnt = 0;
        ImmSrc    = 2'b00;
        imm       = 32'h0000_0800;
        base      = 32'h0000_0013;
        in_valid  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (!in_ready) stall_cnt++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("xact stream 300 error words err_count=%0d", err_count);
        check("stream_no_stall", stall_cnt, 32'd0);
        check("count_saturated", {24'b0, err_count}, 32'hFF);

        // Backpressure: two words buffered, third refused
        out_ready = 1'b0;
        ImmSrc = 2'b00; imm = 32'h0000_0001; base = 32'h0000_0013; in_valid = 1'b1;
        check("bp_a_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        ImmSrc = 2'b01; imm = 32'h0000_0008; base = 32'h0020_A023;
        check("bp_b_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        ImmSrc = 2'b11; imm = 32'h0000_0800; base = 32'h0000_00EF;
        check("bp_c_refused", {31'b0, in_ready}, 32'd0);
        check("bp_a_valid", {31'b0, out_valid}, 32'd1);
        check("bp_a_instr", instr, 32'h0010_0013);
        @(posedge clk); #1;
        check("bp_a_hold", instr, 32'h0010_0013);
        check("bp_c_still_refused", {31'b0, in_ready}, 32'd0);
        $display("xact bp_a held instr=0x%08h", instr);
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_b_valid", {31'b0, out_valid}, 32'd1);
        check("bp_b_instr", instr, 32'h0020_A423);
        $display("xact bp_b instr=0x%08h", instr);
        @(posedge clk); #1;
        check("bp_c_valid", {31'b0, out_valid}, 32'd1);
        check("bp_c_instr", instr, 32'h0010_00EF);
        $display("xact bp_c instr=0x%08h", instr);
        @(posedge clk); #1;
        check("bp_drained", {31'b0, out_valid}, 32'd0);
        check("bp_count_kept", {24'b0, err_count}, 32'hFF);

        // Asynchronous reset with two words in flight
        out_ready = 1'b0;
        ImmSrc = 2'b00; imm = 32'h0000_0005; base = 32'h0000_0013; in_valid = 1'b1;
        @(posedge clk); #1;
        imm = 32'h0000_0006;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid_full", {31'b0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_count", {24'b0, err_count}, 32'd0);
        check("mid_rst_instr", instr, 32'h0);
        $display("xact async reset with 2 words in flight");
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("no_stale_word", {31'b0, out_valid}, 32'd0);
        end
`ifdef IMM_ENCODER_ROUNDTRIP_EN
        check("rt_fail_clear", {31'b0, rt_fail}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
